vec_extract: RTL and testbench
==============================

Name: vec_extract

Overview:
- Width-converting reader/writer; the reverse data path of vec_add.
- Reads a matrix row, stored as PROC_SIZE-bit words in a dual-port vector memory, and writes it byte by byte into the 8-bit S memory, starting at S_START_ADDR.
- Sits between the matrix-row buffer and the S memory in the SDitH datapath.
- Used to move a computed row (e.g. H·sA result) into the S vector region before further GF(256) processing.

Parameters:
- PARAMETER_SET, "L1", selects the defaults below ("L1"/"L2"/"L3").
- MAT_ROW_SIZE_BYTES, 104/159/202 (else 8), number of bytes transferred.
- M, 230/352/480 (else 230), depth of the S memory.
- S_START_ADDR, 126/120/150 (else 3), first S address written.
- N_GF, 8, bytes per vector word.
- PROC_SIZE, N_GF*8, vector word width in bits.
- NUM_WORDS, ceil(MAT_ROW_SIZE_BYTES/N_GF), number of vector words read.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle start pulse.
- o_vec_addr  out  CLOG2(NUM_WORDS)  vector memory read address.
- o_vec_rd  out  1  vector memory read strobe.
- i_vec  in  PROC_SIZE  vector read data; valid 1 cycle after o_vec_rd.
- o_s_addr  out  CLOG2(M)  S memory write address.
- o_s  out  8  S memory write data.
- o_s_wr_en  out  1  S memory write enable.
- o_done  out  1  single-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset: applied on the rising edge with i_rst=1. State returns to IDLE and every output is 0: o_vec_addr, o_vec_rd, o_s_addr, o_s, o_s_wr_en, o_done. Reset mid-operation aborts the transfer with no further writes; the next i_start begins a fresh transfer.
- Byte order:
  - Byte j of the row is word j/N_GF, byte lane j%N_GF.
  - Lane 0 is bits [PROC_SIZE-1:PROC_SIZE-8] (MSB first).
  - Byte j is written to S address S_START_ADDR+j.
- FSM states:
  - IDLE: waits for i_start.
  - FETCH: issues the read for word 0.
  - LOAD: captures i_vec into the shift register.
  - EMIT: shifts out one byte per cycle, prefetching the next word.
  - DONE: pulses o_done, then returns to IDLE.
- Timing, with i_start sampled high at edge E0:
  - Edge E1: o_vec_rd=1, o_vec_addr=0.
  - Edge E3: first write, o_s_wr_en=1, o_s_addr=S_START_ADDR, o_s=byte 0.
  - Writes then continue on consecutive cycles with no gaps.
  - Last write at E(2+MAT_ROW_SIZE_BYTES); o_done=1 for exactly one cycle at E(3+MAT_ROW_SIZE_BYTES).
  - Total = MAT_ROW_SIZE_BYTES+3 cycles (L1: 107).
- Prefetch: the read for word k+1 is issued so that i_vec is valid on the cycle lane N_GF-1 of word k is emitted. The new word is loaded without a bubble.
- o_vec_rd is asserted exactly NUM_WORDS times per transfer, with addresses 0..NUM_WORDS-1 in order. There are no reads past NUM_WORDS-1.
- Partial last word (MAT_ROW_SIZE_BYTES%N_GF≠0, e.g. L2: 159=19*8+7):
  - Only the first MAT_ROW_SIZE_BYTES%N_GF lanes are written.
  - Remaining lanes are discarded, with no write and no S address increment.
- o_s holds its last value when o_s_wr_en=0; o_s_wr_en=0 outside EMIT.
- i_start while not IDLE is ignored. The transfer is not restarted and the pulse is not queued.
- i_start and i_rst in the same cycle: reset wins.
- Address width: the S address counter is CLOG2(M) bits. S_START_ADDR+MAT_ROW_SIZE_BYTES-1 must be < M; this is checked by an elaboration-time assertion in simulation.
- Contents of i_vec are don't-care except in the cycle after o_vec_rd.

Test Plan:
- L1, vector memory word0=0x0001020304050607 … word12 ending in byte 0x67, i_start at t=100ns:
  - S[126..229] = 0x00..0x67.
  - First o_s_wr_en at E3.
  - o_done at E107; the bench prints 107 cycles.
  - S[0..125] unchanged.
- L2 (159 bytes, 20 words), last word 0xA1A2A3A4A5A6A7A8:
  - S[272..278] = A1..A7.
  - 0xA8 is never written; no write to S[279].
  - o_done at E162.
- Read-bus check, L1: exactly 13 o_vec_rd pulses, addresses 0..12 strictly increasing, and exactly 104 contiguous o_s_wr_en cycles with no gap at word boundaries.
- i_start re-pulsed at E20 during an L1 transfer:
  - No effect; single o_done at E107, 104 writes total.
  - A second i_start after o_done repeats an identical transfer.
- i_rst asserted for 1 cycle at E50 of an L1 transfer:
  - All outputs 0 from the next edge; no writes after E50; no o_done.
  - A subsequent i_start completes normally in 107 cycles.
- i_start and i_rst high together from IDLE: module stays IDLE, no reads or writes, o_done stays 0.

Source files
------------

// File: rtl/vec_extract.sv
// vec_extract: reads a matrix row stored as PROC_SIZE-bit words from a
// dual-port vector memory and writes it byte by byte, MSB lane first, into
// the 8-bit S memory starting at S_START_ADDR. The next word is prefetched
// while the current one is still being emitted, so S writes are gap-free.
module vec_extract #(
  parameter string PARAMETER_SET      = "L1",
  parameter int    MAT_ROW_SIZE_BYTES = (PARAMETER_SET == "L1") ? 104 :
                                        (PARAMETER_SET == "L2") ? 159 :
                                        (PARAMETER_SET == "L3") ? 202 : 8,
  parameter int    M                  = (PARAMETER_SET == "L1") ? 230 :
                                        (PARAMETER_SET == "L2") ? 352 :
                                        (PARAMETER_SET == "L3") ? 480 : 230,
  parameter int    S_START_ADDR       = (PARAMETER_SET == "L1") ? 126 :
                                        (PARAMETER_SET == "L2") ? 120 :
                                        (PARAMETER_SET == "L3") ? 150 : 3,
  parameter int    N_GF               = 8,
  parameter int    PROC_SIZE          = N_GF * 8,
  parameter int    NUM_WORDS          = (MAT_ROW_SIZE_BYTES + N_GF - 1) / N_GF,
  parameter int    VA_W               = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter int    SA_W               = $clog2(M)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic [VA_W-1:0]      o_vec_addr,
  output logic                 o_vec_rd,
  input  logic [PROC_SIZE-1:0] i_vec,
  output logic [SA_W-1:0]      o_s_addr,
  output logic [7:0]           o_s,
  output logic                 o_s_wr_en,
  output logic                 o_done
);

  localparam int LANE_W = (N_GF > 1) ? $clog2(N_GF) : 1;
  localparam int CNT_W  = $clog2(MAT_ROW_SIZE_BYTES + 1);

  localparam logic [VA_W-1:0]   LAST_WORD     = VA_W'(NUM_WORDS - 1);
  localparam logic [LANE_W-1:0] PREFETCH_LANE = LANE_W'(N_GF - 2);
  localparam logic [LANE_W-1:0] LAST_LANE     = LANE_W'(N_GF - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE     = CNT_W'(MAT_ROW_SIZE_BYTES - 1);
  localparam logic [SA_W-1:0]   S_START       = SA_W'(S_START_ADDR);

  // The S window must fit inside the S memory, and the prefetch lane
  // (one before the last lane) only exists with at least two lanes.
  if ((S_START_ADDR + MAT_ROW_SIZE_BYTES - 1) >= M) begin : g_bad_s_range
    $error("vec_extract: S_START_ADDR+MAT_ROW_SIZE_BYTES-1 must be below M");
  end
  if (N_GF < 2) begin : g_bad_n_gf
    $error("vec_extract: N_GF must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state;

  logic [VA_W-1:0]       r_vec_addr;
  logic                  r_vec_rd;
  logic [SA_W-1:0]       r_s_addr;
  logic [7:0]            r_s;
  logic                  r_s_wr_en;
  logic                  r_done;
  logic [PROC_SIZE-1:0]  r_shift;
  logic [LANE_W-1:0]     r_lane;
  logic [VA_W-1:0]       r_word;
  logic [CNT_W-1:0]      r_byte_cnt;

  logic [VA_W-1:0]       w_vec_addr;
  logic                  w_vec_rd;
  logic [SA_W-1:0]       w_s_addr;
  logic [7:0]            w_s;
  logic                  w_s_wr_en;
  logic                  w_done;
  logic [PROC_SIZE-1:0]  w_shift;
  logic [LANE_W-1:0]     w_lane;
  logic [VA_W-1:0]       w_word;
  logic [CNT_W-1:0]      w_byte_cnt;

  // State register; reset always wins over a coincident start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state and next-output logic. Lane 0 of every word is taken straight
  // from i_vec (the read data arrives exactly on that cycle); the remaining
  // lanes come from the shift register. The read for the following word is
  // launched while the second-to-last lane is emitted so its data lands just
  // in time for the next lane 0. The transfer ends on the byte count, so any
  // unused lanes of a partial last word are simply never emitted.
  always_comb begin
    w_state    = r_state;
    w_vec_addr = r_vec_addr;
    w_vec_rd   = 1'b0;
    w_s_addr   = r_s_addr;
    w_s        = r_s;
    w_s_wr_en  = 1'b0;
    w_done     = 1'b0;
    w_shift    = r_shift;
    w_lane     = r_lane;
    w_word     = r_word;
    w_byte_cnt = r_byte_cnt;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state = ST_FETCH;
        end
      end

      ST_FETCH: begin
        w_vec_rd   = 1'b1;
        w_vec_addr = '0;
        w_word     = '0;
        w_lane     = '0;
        w_byte_cnt = '0;
        w_state    = ST_LOAD;
      end

      ST_LOAD: begin
        w_state = ST_EMIT;
      end

      ST_EMIT: begin
        w_s_wr_en = 1'b1;
        if (r_lane == '0) begin
          w_s     = i_vec[PROC_SIZE-1 -: 8];
          w_shift = {i_vec[PROC_SIZE-9:0], 8'h00};
        end else begin
          w_s     = r_shift[PROC_SIZE-1 -: 8];
          w_shift = {r_shift[PROC_SIZE-9:0], 8'h00};
        end

        w_s_addr = (r_byte_cnt == '0) ? S_START : r_s_addr + SA_W'(1);

        if ((r_lane == PREFETCH_LANE) && (r_word != LAST_WORD)) begin
          w_vec_rd   = 1'b1;
          w_vec_addr = r_word + VA_W'(1);
        end

        if (r_lane == LAST_LANE) begin
          w_lane = '0;
          w_word = r_word + VA_W'(1);
        end else begin
          w_lane = r_lane + LANE_W'(1);
        end

        if (r_byte_cnt == LAST_BYTE) begin
          w_state = ST_DONE;
        end else begin
          w_byte_cnt = r_byte_cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        w_done  = 1'b1;
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // Output and datapath registers; everything clears on reset so an aborted
  // transfer stops writing immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec_addr <= '0;
      r_vec_rd   <= 1'b0;
      r_s_addr   <= '0;
      r_s        <= '0;
      r_s_wr_en  <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_lane     <= '0;
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_vec_addr <= w_vec_addr;
      r_vec_rd   <= w_vec_rd;
      r_s_addr   <= w_s_addr;
      r_s        <= w_s;
      r_s_wr_en  <= w_s_wr_en;
      r_done     <= w_done;
      r_shift    <= w_shift;
      r_lane     <= w_lane;
      r_word     <= w_word;
      r_byte_cnt <= w_byte_cnt;
    end
  end

  assign o_vec_addr = r_vec_addr;
  assign o_vec_rd   = r_vec_rd;
  assign o_s_addr   = r_s_addr;
  assign o_s        = r_s;
  assign o_s_wr_en  = r_s_wr_en;
  assign o_done     = r_done;

endmodule

// File: tb/tb_vec_extract.sv
// Testbench for vec_extract: one L1 and one L2 instance, each with a
// vector-memory and S-memory model; transfers are described in a table.
`timescale 1ns/1ps
module tb_vec_extract;

  logic        clk;
  logic        start1, rst1, start2, rst2;
  logic [3:0]  addr1;
  logic [4:0]  addr2;
  logic        rd1, rd2;
  logic [63:0] vec1, vec2;
  logic [7:0]  saddr1;
  logic [8:0]  saddr2;
  logic [7:0]  s1, s2;
  logic        we1, we2, done1, done2;

  logic [63:0] vmem1 [13];
  logic [63:0] vmem2 [20];
  logic [7:0]  smem1 [230];
  logic [7:0]  smem2 [352];

  int total;
  int bad;

  logic        cur;
  logic        obsRd, obsWe, obsDone;
  int          obsVAddr, obsSAddr;
  logic [7:0]  obsS;

  vec_extract #(.PARAMETER_SET("L1")) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1),
    .o_vec_addr(addr1), .o_vec_rd(rd1), .i_vec(vec1),
    .o_s_addr(saddr1), .o_s(s1), .o_s_wr_en(we1), .o_done(done1)
  );

  vec_extract #(.PARAMETER_SET("L2")) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2),
    .o_vec_addr(addr2), .o_vec_rd(rd2), .i_vec(vec2),
    .o_s_addr(saddr2), .o_s(s2), .o_s_wr_en(we2), .o_done(done2)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    if (rd1) vec1 <= vmem1[addr1];
    if (rd2) vec2 <= vmem2[addr2];
    if (we1) smem1[saddr1] <= s1;
    if (we2) smem2[saddr2] <= s2;
  end

  assign obsRd    = cur ? rd2 : rd1;
  assign obsWe    = cur ? we2 : we1;
  assign obsDone  = cur ? done2 : done1;
  assign obsVAddr = cur ? int'(addr2) : int'(addr1);
  assign obsSAddr = cur ? int'(saddr2) : int'(saddr1);
  assign obsS     = cur ? s2 : s1;

  typedef struct {
    bit l2;
    int restartAt;
    int resetAt;
    bit rstWithStart;
    int expDone;
    int expDoneCount;
    int expWrites;
    int expReads;
    int expFirstWr;
    int budget;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] expByte(input bit l2, input int j);
    if (l2 && j >= 152) return 8'(8'hA1 + (j - 152));
    return 8'(j);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int reads, writes, firstWr, lastWr, doneCnt, doneAt, sStart, mism, depth;
    cur    = v.l2;
    sStart = v.l2 ? 120 : 126;
    depth  = v.l2 ? 352 : 230;
    for (int a = 0; a < 230; a++) smem1[a] = 8'hEE;
    for (int a = 0; a < 352; a++) smem2[a] = 8'hEE;
    reads = 0; writes = 0; firstWr = -1; lastWr = -1; doneCnt = 0; doneAt = 0;

    @(negedge clk);
    if (v.l2) begin start2 = 1'b1; rst2 = v.rstWithStart; end
    else      begin start1 = 1'b1; rst1 = v.rstWithStart; end
    @(posedge clk);
    #1;
    start1 = 1'b0; start2 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    for (int k = 1; k <= v.budget; k++) begin
      @(negedge clk);
      if (k == v.restartAt) begin
        if (v.l2) start2 = 1'b1; else start1 = 1'b1;
      end
      if (k == v.resetAt) begin
        if (v.l2) rst2 = 1'b1; else rst1 = 1'b1;
      end
      @(posedge clk);
      #1;
      start1 = 1'b0; start2 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

      if (k == v.resetAt)
        checkOutput("outputs after reset", int'({obsRd, obsWe, obsDone}) + obsVAddr + obsSAddr + int'(obsS), 0);
      if (obsRd) begin
        checkOutput("read address", obsVAddr, reads);
        reads++;
      end
      if (obsWe) begin
        checkOutput("write address", obsSAddr, sStart + writes);
        checkOutput("write data", int'(obsS), int'(expByte(v.l2, writes)));
        if (firstWr < 0) firstWr = k;
        lastWr = k;
        writes++;
      end
      if (obsDone) begin
        doneCnt++;
        doneAt = k;
        checkOutput("o_s held at done", int'(obsS), int'(expByte(v.l2, writes - 1)));
      end
    end

    checkOutput("read count", reads, v.expReads);
    checkOutput("write count", writes, v.expWrites);
    checkOutput("first write edge", firstWr, v.expFirstWr);
    if (writes > 0) checkOutput("write contiguity", lastWr - firstWr + 1, writes);
    checkOutput("done count", doneCnt, v.expDoneCount);
    if (v.expDoneCount > 0) begin
      checkOutput("done edge", doneAt, v.expDone);
      $display("[TB] transfer took %0d cycles", doneAt);
    end

    mism = 0;
    for (int a = 0; a < depth; a++) begin
      logic [7:0] want, got;
      want = 8'hEE;
      if (a >= sStart && a < sStart + v.expWrites) want = expByte(v.l2, a - sStart);
      got = v.l2 ? smem2[a] : smem1[a];
      if (got !== want) mism++;
    end
    checkOutput("S memory contents", mism, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cur   = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    rst1 = 1'b1; rst2 = 1'b1;

    for (int w = 0; w < 13; w++)
      for (int l = 0; l < 8; l++) vmem1[w][63-8*l -: 8] = 8'(8*w + l);
    for (int w = 0; w < 19; w++)
      for (int l = 0; l < 8; l++) vmem2[w][63-8*l -: 8] = 8'(8*w + l);
    vmem2[19] = 64'hA1A2A3A4A5A6A7A8;

    //        l2 restart reset both done cnt  wr  rd first budget
    vecs[0] = '{0, 0,   0,   0,  107, 1, 104, 13, 3, 115};
    vecs[1] = '{0, 20,  0,   0,  107, 1, 104, 13, 3, 115};
    vecs[2] = '{0, 0,   0,   0,  107, 1, 104, 13, 3, 115};
    vecs[3] = '{0, 0,   50,  0,  0,   0, 47,  7,  3, 115};
    vecs[4] = '{0, 0,   0,   0,  107, 1, 104, 13, 3, 115};
    vecs[5] = '{1, 0,   0,   0,  162, 1, 159, 20, 3, 170};
    vecs[6] = '{0, 0,   0,   1,  0,   0, 0,   0,  -1, 20};

    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst2 = 1'b0;
    checkOutput("L1 reset outputs", int'({rd1, we1, done1}) + int'(addr1) + int'(saddr1) + int'(s1), 0);
    checkOutput("L2 reset outputs", int'({rd2, we2, done2}) + int'(addr2) + int'(saddr2) + int'(s2), 0);

    while ($time < 90) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      $display("[TB] scenario %0d", i);
      applyStimulus(vecs[i]);
      if (vecs[i].l2) begin
        checkOutput("L2 S[279] untouched", int'(smem2[279]), 8'hEE);
        checkOutput("L2 S[278]", int'(smem2[278]), 8'hA7);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
